// File: rtl/mvm_stream_param.sv
// Streaming signed matrix-vector multiplier: y = A*x, K x K matrix, P MAC lanes.
// A and x are loaded through a valid/ready input stream and persist across runs.
// A run computes P rows per pass, stores y, and streams it out under backpressure.
module mvm_stream_param #(
  parameter int K     = 8,
  parameter int P     = 4,
  parameter int B     = 12,
  parameter int OUT_W = 2*B + $clog2(K)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_matrix,
  input  logic                    load_vector,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [B-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    busy,
  output logic                    done
);

  localparam int NPASS  = K / P;
  localparam int DEPTH  = K * K / P;
  localparam int LA_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PASS_W = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam int LANE_W = (P > 1) ? $clog2(P) : 1;
  localparam int IDX_W  = $clog2(K);
  localparam int COL_W  = $clog2(K + 2);
  localparam int PROD_W = 2 * B;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_X  = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4,
    OUTPUT  = 3'd5
  } state_t;

  state_t state_r;

  // Storage: A split into P lane banks (row r lives in bank r%P), x, and results y
  logic signed [B-1:0]     a_mem_r [P][DEPTH];
  logic signed [B-1:0]     x_mem_r [K];
  logic signed [OUT_W-1:0] y_mem_r [K];

  logic                    in_ready_r, out_valid_r, busy_r, done_r;
  logic signed [OUT_W-1:0] out_data_r;
  logic [IDX_W-1:0]        ld_row_r, ld_col_r, out_idx_r;
  logic [COL_W-1:0]        col_r;
  logic [PASS_W-1:0]       pass_r, wr_pass_r;
  logic                    fin_r, wr_pend_r;

  // MAC pipeline: read stage, product stage, accumulator
  logic signed [B-1:0]      a_rd_r [P];
  logic signed [B-1:0]      x_rd_r;
  logic                     rd_vld_r, rd_first_r;
  logic signed [PROD_W-1:0] prod_r [P];
  logic                     prod_vld_r, prod_first_r;
  logic signed [OUT_W-1:0]  acc_r [P];

  logic             xfer_s, issue_s;
  logic [LANE_W-1:0] a_bank_s;
  logic [LA_W-1:0]   a_addr_s, rd_addr_s;
  logic [IDX_W-1:0]  x_addr_s;

  assign xfer_s    = in_valid && in_ready_r;
  assign issue_s   = (state_r == COMPUTE) && !fin_r && (col_r < COL_W'(K));
  assign a_bank_s  = LANE_W'(int'(ld_row_r) % P);
  assign a_addr_s  = LA_W'((int'(ld_row_r) / P) * K + int'(ld_col_r));
  assign rd_addr_s = LA_W'(int'(pass_r) * K + int'(col_r));
  assign x_addr_s  = IDX_W'(col_r);

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Write accepted input words into the A banks or the x memory
  always_ff @(posedge clk) begin
    if (xfer_s && (state_r == LOAD_A)) a_mem_r[a_bank_s][a_addr_s] <= in_data;
    if (xfer_s && (state_r == LOAD_X)) x_mem_r[ld_col_r] <= in_data;
  end

  // Synchronous column read of all lane banks and the shared x element
  always_ff @(posedge clk) begin
    if (issue_s) begin
      for (int l = 0; l < P; l++) a_rd_r[l] <= a_mem_r[l][rd_addr_s];
      x_rd_r <= x_mem_r[x_addr_s];
    end
  end

  // Store the P finished lane sums of a pass into y
  always_ff @(posedge clk) begin
    if (wr_pend_r) begin
      for (int l = 0; l < P; l++) y_mem_r[IDX_W'(int'(wr_pass_r) * P + l)] <= acc_r[l];
    end
  end

  // Multiply and accumulate; the first column of a pass restarts the sum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_r     <= 1'b0;
      rd_first_r   <= 1'b0;
      prod_vld_r   <= 1'b0;
      prod_first_r <= 1'b0;
      for (int l = 0; l < P; l++) begin
        prod_r[l] <= '0;
        acc_r[l]  <= '0;
      end
    end else begin
      rd_vld_r     <= issue_s;
      rd_first_r   <= issue_s && (col_r == COL_W'(0));
      prod_vld_r   <= rd_vld_r;
      prod_first_r <= rd_first_r;
      for (int l = 0; l < P; l++) begin
        if (rd_vld_r) prod_r[l] <= PROD_W'(a_rd_r[l]) * PROD_W'(x_rd_r);
        if (prod_vld_r) begin
          acc_r[l] <= prod_first_r ? OUT_W'(prod_r[l]) : acc_r[l] + OUT_W'(prod_r[l]);
        end
      end
    end
  end

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      out_data_r  <= '0;
      ld_row_r    <= '0;
      ld_col_r    <= '0;
      out_idx_r   <= '0;
      col_r       <= '0;
      pass_r      <= '0;
      wr_pass_r   <= '0;
      fin_r       <= 1'b0;
      wr_pend_r   <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      wr_pend_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= COMPUTE;
            busy_r  <= 1'b1;
            col_r   <= '0;
            pass_r  <= '0;
            fin_r   <= 1'b0;
          end else if (load_matrix) begin
            state_r    <= LOAD_A;
            busy_r     <= 1'b1;
            in_ready_r <= 1'b1;
            ld_row_r   <= '0;
            ld_col_r   <= '0;
          end else if (load_vector) begin
            state_r    <= LOAD_X;
            busy_r     <= 1'b1;
            in_ready_r <= 1'b1;
            ld_col_r   <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD_A: begin
          if (xfer_s) begin
            if (ld_col_r == IDX_W'(K - 1)) begin
              ld_col_r <= '0;
              if (ld_row_r == IDX_W'(K - 1)) begin
                state_r    <= IDLE;
                in_ready_r <= 1'b0;
                busy_r     <= 1'b0;
                ld_row_r   <= '0;
              end else begin
                ld_row_r <= ld_row_r + IDX_W'(1);
              end
            end else begin
              ld_col_r <= ld_col_r + IDX_W'(1);
            end
          end
        end
        LOAD_X: begin
          if (xfer_s) begin
            if (ld_col_r == IDX_W'(K - 1)) begin
              state_r    <= IDLE;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b0;
              ld_col_r   <= '0;
            end else begin
              ld_col_r <= ld_col_r + IDX_W'(1);
            end
          end
        end
        COMPUTE: begin
          // K reads + 2 flush cycles per pass; one extra cycle lets the last pass write y
          if (fin_r) begin
            state_r <= DRAIN;
            fin_r   <= 1'b0;
          end else if (col_r == COL_W'(K + 1)) begin
            col_r     <= '0;
            wr_pend_r <= 1'b1;
            wr_pass_r <= pass_r;
            if (pass_r == PASS_W'(NPASS - 1)) fin_r <= 1'b1;
            else pass_r <= pass_r + PASS_W'(1);
          end else begin
            col_r <= col_r + COL_W'(1);
          end
        end
        DRAIN: begin
          out_data_r  <= y_mem_r[0];
          out_valid_r <= 1'b1;
          out_idx_r   <= '0;
          state_r     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            if (out_idx_r == IDX_W'(K - 1)) begin
              out_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              out_idx_r   <= '0;
              state_r     <= IDLE;
            end else begin
              out_idx_r  <= out_idx_r + IDX_W'(1);
              out_data_r <= y_mem_r[out_idx_r + IDX_W'(1)];
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mvm_stream_param.md
Name: mvm_stream_param

Overview:
- Parametrised signed matrix-vector multiplier. Computes y = A·x for a K×K matrix A and a K-element vector x, using P parallel MAC lanes.
- Successor to the fixed-size mvm generator outputs. Adds valid/ready streaming on both input and output, output backpressure, matrix reuse across vector loads, and full-precision growth-safe accumulation.
- Sits between the host load stream and the result consumer in the accelerator datapath.

Parameters:
- K, 8: matrix dimension (rows = cols = K). Must be ≥ 2 and divisible by P.
- P, 4: number of parallel MAC lanes (rows computed per pass).
- B, 12: signed input word width.
- OUT_W, 2*B+$clog2(K): signed output and accumulator width. Default 27; cannot overflow.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- load_matrix  in  1  command pulse: next K*K accepted words are A, row-major
- load_vector  in  1  command pulse: next K accepted words are x
- start  in  1  command pulse: compute y = A·x
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  B  signed input word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  OUT_W  signed y element, y[0] first
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last y element is accepted

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - in_ready, out_valid, busy, done = 0; out_data = 0.
  - All counters = 0.
  - Memory contents are undefined after reset.
- States: IDLE, LOAD_A, LOAD_X, COMPUTE, DRAIN, OUTPUT.
- IDLE:
  - Commands are decoded only in IDLE.
  - Priority when several are high in the same cycle: start > load_matrix > load_vector.
  - Commands in any other state are ignored; no queuing.
- LOAD_A:
  - in_ready = 1.
  - A word transfers when in_valid && in_ready.
  - Word n goes to row r = n/K, column c = n%K, stored in lane bank r%P at address (r/P)*K + c.
  - After the K*K-th transfer, go to IDLE.
  - in_valid = 0 stalls the load; the counter holds.
- LOAD_X:
  - Same handshake as LOAD_A. K transfers, then IDLE.
  - Reloading x leaves A intact; reloading A leaves x intact.
- COMPUTE:
  - in_ready = 0.
  - K/P passes. Pass q computes rows q*P .. q*P+P-1.
  - Each pass issues K column reads (one per cycle, all lanes in parallel).
  - Pipeline: synchronous memory read (1 cycle), then registered multiply (1 cycle), then accumulate.
  - Accumulator is cleared at the first column of each pass.
  - Product: B×B signed, sign-extended to OUT_W before the add.
  - At the end of each pass, after a 2-cycle pipeline flush, the P lane results are written to y memory at addresses q*P+lane.
  - Fixed compute latency from start accept to DRAIN entry: (K/P)*(K+2)+1 cycles. For defaults: 21 cycles.
- DRAIN:
  - One cycle to prime the y memory read of address 0.
  - Then go to OUTPUT.
- OUTPUT:
  - out_valid = 1, out_data = y[j].
  - j advances only on out_valid && out_ready.
  - While out_ready = 0, out_data and out_valid hold stable (no bubbles, no drops).
  - After y[K-1] is accepted: done = 1 for one cycle, state = IDLE.
- Arithmetic: two's complement throughout; no saturation, no rounding.
- Start without a prior load: computes on the current memory contents; no error flag.
- Reset mid-operation (any state): immediate return to IDLE. Outputs go to reset values asynchronously, the partial load or result is discarded, and no done pulse is generated.
- Boundary cases:
  - Counters never wrap within a phase.
  - Lane address width: $clog2(K*K/P).
  - Pass counter width: $clog2(K/P), with a minimum of 1 bit.

Test Plan:
- Identity: load A = I8, x = 1..8, start, out_ready held 1 → y = 1,2,3,4,5,6,7,8. done rises exactly 1 cycle after y[7] is accepted; first out_valid appears 22 cycles after start is accepted.
- Extremes: all A = -2048, all x = -2048 → every y = 33554432 (no overflow in 27 bits). Then A = all 2047, x = all -2048 → every y = -33538048.
- Backpressure: random out_ready at 30% duty with A(r,c) = r+c, x = all 1 → y[r] = 8r+28, in order, no drops or duplicates. out_data is stable whenever out_valid && !out_ready.
- Input stalls and reuse: load A with in_valid toggling every other cycle, then load x = all 1, then x = all 2 without reloading A → second y equals exactly 2× the first.
- Command arbitration: pulse start and load_matrix in the same IDLE cycle → compute runs. Pulse load_vector during COMPUTE → ignored, in_ready stays 0, y unchanged.
- Async reset: assert reset mid-COMPUTE, between clock edges → busy, out_valid, in_ready drop before the next edge; no done. A subsequent full load and start gives correct results.
